matmul_operand_skewer: RTL and testbench
========================================

Name: matmul_operand_skewer

Overview:
- Feeds the matrix-multiply PE array directly upstream of it.
- Accepts one column of operand A per beat, packed as MAX_DIM lanes of DATA_WIDTH on a BUS_WIDTH word.
- Emits a diagonally skewed stream in which lane i is delayed i advances relative to lane 0, as the systolic array needs.
- Start is a pulse from the matmul control FSM; done tells the control FSM that the array has received every operand, including the zero tail.

Parameters:
- BUS_WIDTH, 32, width of the packed operand word.
- DATA_WIDTH, 8, width of one matrix element.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH (4), number of lanes and the maximum K and N.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- k_len_i  in  $clog2(MAX_DIM)+1  number of columns to accept, 1..MAX_DIM; latched on start.
- n_dim_i  in  $clog2(MAX_DIM)+1  number of active rows/lanes, 1..MAX_DIM; latched on start.
- col_valid_i  in  1  upstream column valid.
- col_ready_o  out  1  block accepts a column this cycle.
- col_data_i  in  BUS_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH] = A[i][k].
- skew_valid_o  out  1  skew_data_o is valid; downstream never stalls.
- skew_data_o  out  BUS_WIDTH  skewed lanes, same packing as col_data_i.
- busy_o  out  1  high in FEED and DRAIN.
- done_o  out  1  one-cycle pulse when the operation completes.

Behaviour:
- Reset: state IDLE, all skew registers 0, col_ready_o=0, skew_valid_o=0, skew_data_o=0, busy_o=0, done_o=0, counters 0. A reset in any state aborts the operation immediately; nothing is emitted afterward.
- Storage: lane i owns a shift chain of i+1 registers. The chain output is skew_data_o lane i.
- Advance: a single global advance shifts every chain by one position.
  - In FEED, an advance occurs only on an accept (col_valid_i & col_ready_o). Each chain head loads col_data_i lane i, or 0 if i >= latched n_dim.
  - In DRAIN, an advance occurs every cycle and zeros are loaded.
  - With no advance, all chains hold and skew_valid_o=0 on the next cycle. This preserves diagonal alignment across upstream bubbles.
- Output timing: skew_valid_o is registered and equals "an advance occurred in the previous cycle". Lane i shows the element accepted i advances before the current one.
- FSM:
  - IDLE: col_ready_o=0. On start_i, latch k_len_i and n_dim_i, clear acc_cnt, go to FEED. Out-of-range k_len_i or n_dim_i (0 or >MAX_DIM) is clamped to MAX_DIM.
  - FEED: col_ready_o=1. acc_cnt increments on each accept. The accept that makes acc_cnt==k_len moves to DRAIN in the next cycle, unless MAX_DIM==1, in which case go to DONE.
  - DRAIN: col_ready_o=0. drn_cnt counts MAX_DIM-1 advances, then go to DONE.
  - DONE: one cycle. done_o=1; this cycle also carries the last skew_valid_o. Return to IDLE.
- Totals: exactly k_len+MAX_DIM-1 skew_valid_o beats per operation. No gaps once upstream streams continuously.
- Latency: first accept to first skew_valid_o is 1 cycle. Last accept to done_o is MAX_DIM cycles.
- Simultaneous events: start_i outside IDLE is ignored. A start_i in the DONE cycle is ignored; the earliest restart is the cycle after done_o. In IDLE, col_valid_i is ignored and no data is consumed.
- Chains are not cleared between operations. The drain flushes them to zero, so the first beat of the next operation has zeros above the diagonal.

Optional Feature:
- Macro: MATMUL_SKEW_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o, width 16.
  - Cleared on start, counts FEED cycles with col_valid_i=0, saturates at 16'hFFFF, and holds its value in IDLE for readback over APB.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-FEED (after 2 accepts, rst_i=1 for 1 cycle) -> next cycle all outputs 0, state IDLE. No skew_valid_o and no done_o until a new start.
- k_len=4, n_dim=4, columns 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D streamed back-to-back -> 7 valid beats, in order 0x00000001, 0x00000205, 0x00030609, 0x04070A0D, 0x080B0E00, 0x0C0F0000, 0x10000000. done_o is high together with the 7th beat.
- Same stimulus with col_valid_i=0 for 2 cycles after the 2nd column -> skew_valid_o low for exactly 2 cycles and identical beat values. With MATMUL_SKEW_STALL_CNT_EN, stall_cnt_o=2.
- k_len=2, n_dim=2, columns 0xFFFFFFFF, 0xAAAAAAAA -> lanes 2 and 3 are always 0. Beats in order: 0x000000FF, 0x0000FFAA, 0x0000AA00, 0x00000000, 0x00000000 (5 beats). done_o pulses once.
- start_i during FEED and again in the DONE cycle -> ignored: latched k_len unchanged, single done_o. A start in the cycle after DONE begins a new operation.
- k_len_i=0, n_dim_i=7 -> clamped to 4; col_ready_o stays high for exactly 4 accepts.

Source files
------------

// File: rtl/matmul_operand_skewer.sv
// rtl/matmul_operand_skewer.sv - diagonal operand skewer feeding the systolic matmul PE array; optional stall counter under MATMUL_SKEW_STALL_CNT_EN
module matmul_operand_skewer #(
  parameter  int BUS_WIDTH  = 32,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int CW         = $clog2(MAX_DIM) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CW-1:0]        k_len_i,
  input  logic [CW-1:0]        n_dim_i,
  input  logic                 col_valid_i,
  output logic                 col_ready_o,
  input  logic [BUS_WIDTH-1:0] col_data_i,
  output logic                 skew_valid_o,
  output logic [BUS_WIDTH-1:0] skew_data_o,
`ifdef MATMUL_SKEW_STALL_CNT_EN
  output logic [15:0]          stall_cnt_o,
`endif
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] k_len_q;
  logic [CW-1:0] n_dim_q;
  logic [CW-1:0] acc_cnt_q;
  logic [CW-1:0] drn_cnt_q;
  logic          col_ready_q;
  logic          busy_q;
  logic          done_q;
  logic          skew_valid_q;

  logic [CW-1:0] k_len_d;
  logic [CW-1:0] n_dim_d;
  logic          accept;
  logic          advance;

  // Zero or oversize lengths fall back to the full array dimension.
  assign k_len_d = ((k_len_i == '0) || (k_len_i > CW'(MAX_DIM))) ? CW'(MAX_DIM) : k_len_i;
  assign n_dim_d = ((n_dim_i == '0) || (n_dim_i > CW'(MAX_DIM))) ? CW'(MAX_DIM) : n_dim_i;

  // col_ready_q is only high in FEED, so an accept can only happen there.
  assign accept  = col_ready_q & col_valid_i;
  assign advance = accept | (state_q == S_DRAIN);

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      n_dim_q     <= '0;
      acc_cnt_q   <= '0;
      drn_cnt_q   <= '0;
      col_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            k_len_q     <= k_len_d;
            n_dim_q     <= n_dim_d;
            acc_cnt_q   <= '0;
            drn_cnt_q   <= '0;
            col_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_FEED;
          end
        end
        S_FEED: begin
          if (col_valid_i) begin
            acc_cnt_q <= acc_cnt_q + CW'(1);
            if ((acc_cnt_q + CW'(1)) == k_len_q) begin
              col_ready_q <= 1'b0;
              if (MAX_DIM == 1) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                state_q <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (drn_cnt_q == CW'(MAX_DIM - 2)) begin
            drn_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            drn_cnt_q <= drn_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output valid marks that the chains advanced on the previous edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skew_valid_q <= 1'b0;
    end else begin
      skew_valid_q <= advance;
    end
  end

  for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] chain_q [0:i];
    logic [DATA_WIDTH-1:0] head_d;

    // Lanes beyond the active row count, and every drain advance, feed zeros.
    assign head_d = (accept && (CW'(i) < n_dim_q)) ? col_data_i[i*DATA_WIDTH +: DATA_WIDTH]
                                                   : '0;

    // Lane i is a shift chain of i+1 stages moved by the shared advance.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int j = 0; j <= i; j++) begin
          chain_q[j] <= '0;
        end
      end else if (advance) begin
        chain_q[0] <= head_d;
        for (int j = 1; j <= i; j++) begin
          chain_q[j] <= chain_q[j-1];
        end
      end
    end

    assign skew_data_o[i*DATA_WIDTH +: DATA_WIDTH] = chain_q[i];
  end

`ifdef MATMUL_SKEW_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Counts upstream bubbles while feeding; value is kept in IDLE for readback.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && start_i) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_FEED) && !col_valid_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign col_ready_o  = col_ready_q;
  assign skew_valid_o = skew_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_matmul_operand_skewer.sv
// tb/tb_matmul_operand_skewer.sv - randomized self-checking bench for matmul_operand_skewer
`timescale 1ns/1ps
module tb_matmul_operand_skewer;
  localparam int BW = 32;
  localparam int DW = 8;
  localparam int MD = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [CW-1:0] k_len_i;
  logic [CW-1:0] n_dim_i;
  logic          col_valid_i;
  logic          col_ready_o;
  logic [BW-1:0] col_data_i;
  logic          skew_valid_o;
  logic [BW-1:0] skew_data_o;
  logic          busy_o;
  logic          done_o;
`ifdef MATMUL_SKEW_STALL_CNT_EN
  logic [15:0]   stall_cnt_o;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  matmul_operand_skewer #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .k_len_i      (k_len_i),
    .n_dim_i      (n_dim_i),
    .col_valid_i  (col_valid_i),
    .col_ready_o  (col_ready_o),
    .col_data_i   (col_data_i),
    .skew_valid_o (skew_valid_o),
    .skew_data_o  (skew_data_o),
`ifdef MATMUL_SKEW_STALL_CNT_EN
    .stall_cnt_o  (stall_cnt_o),
`endif
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // Output monitor, sampled 2ns after each rising edge.
  logic [BW-1:0] beats[$];
  int vhist[$];
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int done_valid = 0;
  int beats_at_done = 0;
  int first_valid_cyc = -1;

  always @(posedge clk) begin
    #2;
    cyc++;
    vhist.push_back((skew_valid_o === 1'b1) ? 1 : 0);
    if (skew_valid_o === 1'b1) begin
      beats.push_back(skew_data_o);
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_valid = (skew_valid_o === 1'b1) ? 1 : 0;
      beats_at_done = beats.size();
    end
  end

  // Reference: beat t, lane i carries column t-i when that column exists and the row is active.
  function automatic logic [BW-1:0] model_beat(int t, int k, int n, logic [BW-1:0] cols[$]);
    logic [BW-1:0] r;
    logic [BW-1:0] c;
    int src;
    r = '0;
    for (int i = 0; i < MD; i++) begin
      src = t - i;
      if (i < n && src >= 0 && src < k) begin
        c = cols[src];
        r[i*DW +: DW] = c[i*DW +: DW];
      end
    end
    return r;
  endfunction

  function automatic int eff_len(int v);
    return (v < 1 || v > MD) ? MD : v;
  endfunction

  function automatic int count_gaps();
    int first = -1;
    int last = -1;
    int g = 0;
    foreach (vhist[i]) begin
      if (vhist[i] != 0) begin
        if (first < 0) first = i;
        last = i;
      end
    end
    if (first >= 0) begin
      for (int i = first; i <= last; i++) if (vhist[i] == 0) g++;
    end
    return g;
  endfunction

  int acc_n;
  int first_acc_cyc;
  int last_acc_cyc;
  int timed_out;

  // Runs one operation starting at the current falling edge; returns one cycle after DONE.
  task automatic drive_op(input int k_in, input int n_in, input logic [BW-1:0] cols[$],
                          input int bub_at, input int bub_len,
                          input int start_in_feed, input int start_at_done);
    int idx = 0;
    int bub = 0;
    int guard = 0;
    beats.delete();
    vhist.delete();
    done_cnt = 0;
    done_cyc = -1;
    done_valid = 0;
    beats_at_done = 0;
    first_valid_cyc = -1;
    acc_n = 0;
    first_acc_cyc = -1;
    last_acc_cyc = -1;
    timed_out = 0;
    start_i = 1'b1;
    k_len_i = CW'(k_in);
    n_dim_i = CW'(n_in);
    @(negedge clk);
    start_i = 1'b0;
    while (done_cnt == 0 && guard < 100) begin
      start_i = 1'b0;
      if (idx == bub_at && bub < bub_len) begin
        col_valid_i = 1'b0;
        col_data_i = $urandom;
        bub++;
      end else if (idx < cols.size()) begin
        col_valid_i = 1'b1;
        col_data_i = cols[idx];
      end else begin
        col_valid_i = 1'b0;
        col_data_i = $urandom;
      end
      if (start_in_feed != 0 && idx == 1) begin
        start_i = 1'b1;
        k_len_i = CW'(1);
      end
      if (col_valid_i && col_ready_o) begin
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        idx++;
        acc_n++;
      end
      @(negedge clk);
      guard++;
    end
    col_valid_i = 1'b0;
    start_i = 1'b0;
    if (done_cnt == 0) timed_out = 1;
    if (start_at_done != 0) begin
      start_i = 1'b1;
      k_len_i = CW'(1);
      n_dim_i = CW'(1);
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (col_ready_o !== 1'b0) $display("FAIL reset col_ready: got %b expected 0", col_ready_o); else pass_cnt++;
    total_cnt++; if (skew_valid_o !== 1'b0) $display("FAIL reset skew_valid: got %b expected 0", skew_valid_o); else pass_cnt++;
    total_cnt++; if (skew_data_o !== '0) $display("FAIL reset skew_data: got %h expected 0", skew_data_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy_o); else pass_cnt++;
    total_cnt++; if (done_o !== 1'b0) $display("FAIL reset done: got %b expected 0", done_o); else pass_cnt++;
`ifdef MATMUL_SKEW_STALL_CNT_EN
    total_cnt++; if (stall_cnt_o !== 16'd0) $display("FAIL reset stall_cnt: got %0d expected 0", stall_cnt_o); else pass_cnt++;
`endif
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_feed();
    int vsum = 0;
    start_i = 1'b1; k_len_i = 3'd4; n_dim_i = 3'd4;
    @(negedge clk);
    start_i = 1'b0;
    col_valid_i = 1'b1; col_data_i = 32'h04030201;
    @(negedge clk);
    col_data_i = 32'h08070605;
    @(negedge clk);
    col_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    total_cnt++; if (col_ready_o !== 1'b0) $display("FAIL midrst col_ready: got %b expected 0", col_ready_o); else pass_cnt++;
    total_cnt++; if (skew_valid_o !== 1'b0) $display("FAIL midrst skew_valid: got %b expected 0", skew_valid_o); else pass_cnt++;
    total_cnt++; if (skew_data_o !== '0) $display("FAIL midrst skew_data: got %h expected 0", skew_data_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL midrst busy: got %b expected 0", busy_o); else pass_cnt++;
    total_cnt++; if (done_o !== 1'b0) $display("FAIL midrst done: got %b expected 0", done_o); else pass_cnt++;
    vhist.delete(); beats.delete(); done_cnt = 0;
    col_valid_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      col_data_i = $urandom;
      @(negedge clk);
    end
    col_valid_i = 1'b0;
    foreach (vhist[i]) vsum += vhist[i];
    total_cnt++; if (vsum != 0) $display("FAIL midrst idle_valid: got %0d beats expected 0", vsum); else pass_cnt++;
    total_cnt++; if (done_cnt != 0) $display("FAIL midrst idle_done: got %0d expected 0", done_cnt); else pass_cnt++;
    total_cnt++; if (col_ready_o !== 1'b0) $display("FAIL midrst idle_ready: got %b expected 0", col_ready_o); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [BW-1:0] cols[$];
    logic [BW-1:0] exp_tbl[7];
    logic [BW-1:0] got;
    cols = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    exp_tbl = '{32'h00000001, 32'h00000205, 32'h00030609, 32'h04070A0D,
                32'h080B0E00, 32'h0C0F0000, 32'h10000000};
    drive_op(4, 4, cols, -1, 0, 0, 0);
    total_cnt++; if (timed_out != 0) $display("FAIL basic timeout: got no done expected done"); else pass_cnt++;
    total_cnt++; if (beats.size() != 7) $display("FAIL basic nbeats: got %0d expected 7", beats.size()); else pass_cnt++;
    for (int t = 0; t < 7; t++) begin
      got = (t < beats.size()) ? beats[t] : 'x;
      total_cnt++; if (got !== exp_tbl[t]) $display("FAIL basic beat%0d: got %h expected %h", t, got, exp_tbl[t]); else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL basic done_count: got %0d expected 1", done_cnt); else pass_cnt++;
    total_cnt++; if (done_valid != 1 || beats_at_done != 7) $display("FAIL basic done_with_last: got valid=%0d beats=%0d expected valid=1 beats=7", done_valid, beats_at_done); else pass_cnt++;
    total_cnt++; if (first_valid_cyc - first_acc_cyc != 1) $display("FAIL basic first_latency: got %0d expected 1", first_valid_cyc - first_acc_cyc); else pass_cnt++;
    total_cnt++; if (done_cyc - last_acc_cyc != MD) $display("FAIL basic done_latency: got %0d expected %0d", done_cyc - last_acc_cyc, MD); else pass_cnt++;
    total_cnt++; if (count_gaps() != 0) $display("FAIL basic gaps: got %0d expected 0", count_gaps()); else pass_cnt++;
  endtask

  task automatic test_bubbles();
    logic [BW-1:0] cols[$];
    logic [BW-1:0] exp_tbl[7];
    logic [BW-1:0] got;
    cols = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    exp_tbl = '{32'h00000001, 32'h00000205, 32'h00030609, 32'h04070A0D,
                32'h080B0E00, 32'h0C0F0000, 32'h10000000};
    drive_op(4, 4, cols, 2, 2, 0, 0);
    total_cnt++; if (beats.size() != 7) $display("FAIL bubble nbeats: got %0d expected 7", beats.size()); else pass_cnt++;
    for (int t = 0; t < 7; t++) begin
      got = (t < beats.size()) ? beats[t] : 'x;
      total_cnt++; if (got !== exp_tbl[t]) $display("FAIL bubble beat%0d: got %h expected %h", t, got, exp_tbl[t]); else pass_cnt++;
    end
    total_cnt++; if (count_gaps() != 2) $display("FAIL bubble gaps: got %0d expected 2", count_gaps()); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL bubble done_count: got %0d expected 1", done_cnt); else pass_cnt++;
`ifdef MATMUL_SKEW_STALL_CNT_EN
    total_cnt++; if (stall_cnt_o !== 16'd2) $display("FAIL bubble stall_cnt: got %0d expected 2", stall_cnt_o); else pass_cnt++;
`endif
  endtask

  task automatic test_narrow();
    logic [BW-1:0] cols[$];
    logic [BW-1:0] exp_tbl[5];
    logic [BW-1:0] got;
    cols = '{32'hFFFFFFFF, 32'hAAAAAAAA};
    exp_tbl = '{32'h000000FF, 32'h0000FFAA, 32'h0000AA00, 32'h00000000, 32'h00000000};
    drive_op(2, 2, cols, -1, 0, 0, 0);
    total_cnt++; if (beats.size() != 5) $display("FAIL narrow nbeats: got %0d expected 5", beats.size()); else pass_cnt++;
    for (int t = 0; t < 5; t++) begin
      got = (t < beats.size()) ? beats[t] : 'x;
      total_cnt++; if (got !== exp_tbl[t]) $display("FAIL narrow beat%0d: got %h expected %h", t, got, exp_tbl[t]); else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL narrow done_count: got %0d expected 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    logic [BW-1:0] cols[$];
    logic [BW-1:0] cols2[$];
    logic [BW-1:0] got;
    logic [BW-1:0] exp;
    for (int c = 0; c < 3; c++) cols.push_back($urandom);
    for (int c = 0; c < 2; c++) cols2.push_back($urandom);
    drive_op(3, 4, cols, -1, 0, 1, 1);
    total_cnt++; if (acc_n != 3) $display("FAIL startign accepts: got %0d expected 3", acc_n); else pass_cnt++;
    total_cnt++; if (beats.size() != 6) $display("FAIL startign nbeats: got %0d expected 6", beats.size()); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL startign done_count: got %0d expected 1", done_cnt); else pass_cnt++;
    for (int t = 0; t < 6; t++) begin
      got = (t < beats.size()) ? beats[t] : 'x;
      exp = model_beat(t, 3, 4, cols);
      total_cnt++; if (got !== exp) $display("FAIL startign beat%0d: got %h expected %h", t, got, exp); else pass_cnt++;
    end
    drive_op(2, 3, cols2, -1, 0, 0, 0);
    total_cnt++; if (timed_out != 0) $display("FAIL restart timeout: got no done expected done"); else pass_cnt++;
    total_cnt++; if (acc_n != 2) $display("FAIL restart accepts: got %0d expected 2", acc_n); else pass_cnt++;
    total_cnt++; if (beats.size() != 5) $display("FAIL restart nbeats: got %0d expected 5", beats.size()); else pass_cnt++;
    for (int t = 0; t < 5; t++) begin
      got = (t < beats.size()) ? beats[t] : 'x;
      exp = model_beat(t, 2, 3, cols2);
      total_cnt++; if (got !== exp) $display("FAIL restart beat%0d: got %h expected %h", t, got, exp); else pass_cnt++;
    end
  endtask

  task automatic test_clamp();
    logic [BW-1:0] cols[$];
    logic [BW-1:0] got;
    logic [BW-1:0] exp;
    for (int c = 0; c < 6; c++) cols.push_back($urandom);
    drive_op(0, 7, cols, -1, 0, 0, 0);
    total_cnt++; if (acc_n != MD) $display("FAIL clamp accepts: got %0d expected %0d", acc_n, MD); else pass_cnt++;
    total_cnt++; if (beats.size() != 2*MD-1) $display("FAIL clamp nbeats: got %0d expected %0d", beats.size(), 2*MD-1); else pass_cnt++;
    for (int t = 0; t < 2*MD-1; t++) begin
      got = (t < beats.size()) ? beats[t] : 'x;
      exp = model_beat(t, eff_len(0), eff_len(7), cols);
      total_cnt++; if (got !== exp) $display("FAIL clamp beat%0d: got %h expected %h", t, got, exp); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [BW-1:0] cols[$];
    logic [BW-1:0] got;
    logic [BW-1:0] exp;
    int k, n, bat, blen, nb;
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(1, MD);
      n = $urandom_range(1, MD);
      bat = (k > 1) ? $urandom_range(1, k-1) : -1;
      blen = (k > 1) ? $urandom_range(0, 3) : 0;
      cols.delete();
      for (int c = 0; c < k; c++) cols.push_back($urandom);
      drive_op(k, n, cols, bat, blen, 0, 0);
      nb = k + MD - 1;
      total_cnt++; if (timed_out != 0) $display("FAIL rand%0d timeout: got no done expected done", it); else pass_cnt++;
      total_cnt++; if (beats.size() != nb) $display("FAIL rand%0d nbeats: got %0d expected %0d", it, beats.size(), nb); else pass_cnt++;
      for (int t = 0; t < nb; t++) begin
        got = (t < beats.size()) ? beats[t] : 'x;
        exp = model_beat(t, k, n, cols);
        total_cnt++; if (got !== exp) $display("FAIL rand%0d beat%0d: got %h expected %h", it, t, got, exp); else pass_cnt++;
      end
      total_cnt++; if (count_gaps() != blen) $display("FAIL rand%0d gaps: got %0d expected %0d", it, count_gaps(), blen); else pass_cnt++;
      total_cnt++; if (done_valid != 1 || done_cnt != 1) $display("FAIL rand%0d done: got valid=%0d count=%0d expected 1/1", it, done_valid, done_cnt); else pass_cnt++;
`ifdef MATMUL_SKEW_STALL_CNT_EN
      total_cnt++; if (stall_cnt_o !== 16'(blen)) $display("FAIL rand%0d stall_cnt: got %0d expected %0d", it, stall_cnt_o, blen); else pass_cnt++;
`endif
    end
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    k_len_i = '0;
    n_dim_i = '0;
    col_valid_i = 1'b0;
    col_data_i = '0;
    test_reset();
    test_basic();
    test_reset_mid_feed();
    test_basic();
    test_bubbles();
    test_narrow();
    test_start_ignored();
    test_clamp();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
